// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the mp1 memory port between instruction fetch and data access
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   i_read, i_address        instruction read request, held until i_resp
//   i_rdata, i_resp          instruction read data and one-cycle completion pulse
//   d_read, d_write          data read / write request, held until d_resp
//   d_byte_enable, d_address, d_wdata   data write mask, address, write data
//   d_rdata, d_resp          data read data and one-cycle completion pulse
//   mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata   registered memory request
//   mem_rdata, mem_resp      memory read data and completion pulse
//   err_timeout, err_proto   sticky error flags, cleared only by reset
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_read,
  input  logic [ADDR_WIDTH-1:0]   i_address,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_resp,
  input  logic                    d_read,
  input  logic                    d_write,
  input  logic [DATA_WIDTH/8-1:0] d_byte_enable,
  input  logic [ADDR_WIDTH-1:0]   d_address,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_resp,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_resp,
  output logic                    err_timeout,
  output logic                    err_proto
);

  // Counter wide enough to reach TIMEOUT_CYCLES-1 and still saturate cleanly.
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SERV_I = 2'd1;
  localparam logic [1:0] SERV_D = 2'd2;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  logic [1:0]           state;
  logic                 last_grant;
  logic [CNT_WIDTH-1:0] wdog_cnt;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;
  logic serving;
  logic timeout_hit;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // Under contention the requester that did not win last time gets the port.
  assign grant_i = (state == IDLE) && i_req && (!d_req || (last_grant == GRANT_D));
  assign grant_d = (state == IDLE) && d_req && (!i_req || (last_grant == GRANT_I));

  assign serving     = (state == SERV_I) || (state == SERV_D);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && serving && !mem_resp && (wdog_cnt == CNT_LAST);

  // Read data is broadcast; only the owner sees a completion pulse.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  assign i_resp  = (state == SERV_I) && mem_resp;
  assign d_resp  = (state == SERV_D) && mem_resp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      last_grant      <= GRANT_D;
      wdog_cnt        <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_byte_enable <= '0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      err_timeout     <= 1'b0;
      err_proto       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            state           <= SERV_I;
            last_grant      <= GRANT_I;
            wdog_cnt        <= '0;
            mem_read        <= 1'b1;
            mem_write       <= 1'b0;
            mem_byte_enable <= '1;
            mem_address     <= i_address;
          end else if (grant_d) begin
            state           <= SERV_D;
            last_grant      <= GRANT_D;
            wdog_cnt        <= '0;
            // A simultaneous read+write goes out as a write only.
            mem_read        <= d_read & ~d_write;
            mem_write       <= d_write;
            mem_byte_enable <= d_byte_enable;
            mem_address     <= d_address;
            mem_wdata       <= d_wdata;
            if (d_read && d_write) begin
              err_proto <= 1'b1;
            end
          end
        end
        SERV_I, SERV_D: begin
          if (mem_resp || timeout_hit) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (timeout_hit) begin
              err_timeout <= 1'b1;
            end
          end else if (wdog_cnt != '1) begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_read = 1'b0;
  logic [31:0] i_address = '0;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [3:0]  d_byte_enable = '0;
  logic [31:0] d_address = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        err_timeout;
  logic        err_proto;

  logic        auto_en = 1'b0;
  logic        a_resp = 1'b0;
  logic [31:0] a_rdata = '0;
  logic        m_resp = 1'b0;
  logic [31:0] m_rdata = '0;

  assign mem_resp  = auto_en ? a_resp  : m_resp;
  assign mem_rdata = auto_en ? a_rdata : m_rdata;

  int n_chk = 0;
  int n_fail = 0;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
    .d_address(d_address), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .err_timeout(err_timeout), .err_proto(err_proto)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm, input string why);
    n_chk++;
    n_fail++;
    $display("FAIL %s: %s", nm, why);
  endtask

  // Memory contents: ref_mem follows the requesters' intent, phys_mem follows the bus.
  logic [31:0] ref_mem  [logic [31:0]];
  logic [31:0] phys_mem [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_val(a);
  endfunction

  // Auto-responding memory: random 0..3 extra wait cycles per transaction.
  initial begin
    int left;
    left = -1;
    forever begin
      tick();
      a_resp = 1'b0;
      if (auto_en && (mem_read || mem_write)) begin
        if (left < 0) left = int'($urandom_range(0, 3));
        if (left == 0) begin
          a_resp = 1'b1;
          if (mem_write) phys_mem[mem_address] = merge(phys_rd(mem_address), mem_wdata, mem_byte_enable);
          else a_rdata = phys_rd(mem_address);
          left = -1;
        end else begin
          left--;
        end
      end else begin
        left = -1;
      end
    end
  end

  // Scoreboard monitor.
  logic        mon_en = 1'b0;
  logic [31:0] i_exp_q[$];
  logic [32:0] d_exp_q[$];
  int          grant_log[$];
  int          lg;
  logic        p_low, p_ireq, p_dreq, p_dr, p_dw;
  logic [31:0] p_iaddr, p_daddr, p_dwdata;
  logic [3:0]  p_dbe;

  initial begin
    int w;
    logic [32:0] e;
    forever begin
      smp();
      if (mon_en) begin
        if (p_low && (p_ireq || p_dreq)) begin
          if (p_ireq && p_dreq) w = (lg == 1) ? 0 : 1;
          else w = p_ireq ? 0 : 1;
          chk("grant_follows_idle", {62'd0, mem_read, mem_write} != 0, 1);
          if (w == 0) begin
            chk("grant_i_fields", {mem_read, mem_write, mem_byte_enable, mem_address},
                {1'b1, 1'b0, 4'hF, p_iaddr});
          end else begin
            chk("grant_d_fields", {mem_read, mem_write, mem_byte_enable, mem_address},
                {p_dr & ~p_dw, p_dw, p_dbe, p_daddr});
            chk("grant_d_wdata", mem_wdata, p_dwdata);
          end
          lg = w;
          grant_log.push_back(w);
        end
        if (i_resp) begin
          if (i_exp_q.size() == 0) fail("i_resp_spurious", "i_resp with nothing outstanding");
          else chk("i_rdata", i_rdata, i_exp_q.pop_front());
        end
        if (d_resp) begin
          if (d_exp_q.size() == 0) fail("d_resp_spurious", "d_resp with nothing outstanding");
          else begin
            e = d_exp_q.pop_front();
            if (e[32]) chk("d_rdata", d_rdata, e[31:0]);
          end
        end
        p_low    = !(mem_read || mem_write);
        p_ireq   = i_read;
        p_dreq   = d_read | d_write;
        p_dr     = d_read;
        p_dw     = d_write;
        p_iaddr  = i_address;
        p_daddr  = d_address;
        p_dwdata = d_wdata;
        p_dbe    = d_byte_enable;
      end
    end
  end

  task automatic run_i(input int n);
    int gap;
    int t;
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      gap = (k == 0 || $urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      repeat (gap) tick();
      a = 32'($urandom_range(0, 63)) << 2;
      i_address = a;
      i_read = 1'b1;
      i_exp_q.push_back(ref_rd(a));
      t = 0;
      do begin smp(); t++; end while (!i_resp && t < 100);
      if (!i_resp) fail("i_resp_wait", "no i_resp within 100 cycles");
      tick();
      i_read = 1'b0;
    end
  endtask

  task automatic run_d(input int n);
    int gap;
    int t;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    for (int k = 0; k < n; k++) begin
      gap = (k == 0 || $urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      repeat (gap) tick();
      a  = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
      wd = $urandom;
      be = 4'($urandom_range(1, 15));
      d_address = a;
      d_wdata = wd;
      d_byte_enable = be;
      if ($urandom_range(0, 1) == 1) begin
        d_write = 1'b1;
        ref_mem[a] = merge(ref_rd(a), wd, be);
        d_exp_q.push_back({1'b0, 32'd0});
      end else begin
        d_read = 1'b1;
        d_exp_q.push_back({1'b1, ref_rd(a)});
      end
      t = 0;
      do begin smp(); t++; end while (!d_resp && t < 100);
      if (!d_resp) fail("d_resp_wait", "no d_resp within 100 cycles");
      tick();
      d_read = 1'b0;
      d_write = 1'b0;
    end
  endtask

  initial begin
    int held;

    // Reset values.
    repeat (2) smp();
    chk("rst_strobes", {mem_read, mem_write}, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_be", mem_byte_enable, 0);
    chk("rst_resp", {i_resp, d_resp}, 0);
    chk("rst_err", {err_timeout, err_proto}, 0);
    tick();
    rst = 1'b1;

    // Single fetch with a three-cycle memory response.
    tick();
    i_read = 1'b1;
    i_address = 32'h60;
    smp();
    chk("fetch_not_before_edge", mem_read, 0);
    tick();
    smp();
    chk("fetch_issue", {mem_read, mem_write, mem_byte_enable, mem_address}, {1'b1, 1'b0, 4'hF, 32'h60});
    tick();
    smp();
    chk("fetch_held", mem_read, 1);
    tick();
    m_resp = 1'b1;
    m_rdata = 32'h0000_0013;
    smp();
    chk("fetch_resp", {i_resp, d_resp}, 2'b10);
    chk("fetch_rdata", i_rdata, 32'h13);
    tick();
    m_resp = 1'b0;
    i_read = 1'b0;
    smp();
    chk("fetch_done", {i_resp, mem_read}, 0);

    // Stray mem_resp while idle.
    tick();
    m_resp = 1'b1;
    smp();
    chk("idle_resp_ignored", {i_resp, d_resp}, 0);
    tick();
    m_resp = 1'b0;

    // Masked write; requester inputs changed while served must not leak through.
    tick();
    d_write = 1'b1;
    d_address = 32'h1004;
    d_wdata = 32'hDEAD_BEEF;
    d_byte_enable = 4'b0011;
    tick();
    d_write = 1'b0;
    d_address = 32'hFFFF;
    d_wdata = 32'h0;
    smp();
    chk("write_issue", {mem_read, mem_write, mem_byte_enable, mem_address}, {1'b0, 1'b1, 4'b0011, 32'h1004});
    chk("write_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    m_resp = 1'b1;
    smp();
    chk("write_resp", {i_resp, d_resp, mem_read, mem_write}, 4'b0101);
    tick();
    m_resp = 1'b0;
    smp();
    chk("write_done", {d_resp, mem_write}, 0);

    // Read and write together: write only, sticky protocol flag.
    tick();
    d_read = 1'b1;
    d_write = 1'b1;
    d_address = 32'h1008;
    tick();
    d_read = 1'b0;
    d_write = 1'b0;
    smp();
    chk("proto_write_only", {mem_read, mem_write}, 2'b01);
    chk("proto_flag", err_proto, 1);
    tick();
    m_resp = 1'b1;
    smp();
    chk("proto_resp", d_resp, 1);
    tick();
    m_resp = 1'b0;
    repeat (2) tick();
    smp();
    chk("proto_sticky", err_proto, 1);

    // Watchdog with a pending fetch queued behind the hung data read.
    tick();
    d_read = 1'b1;
    d_address = 32'h1010;
    tick();
    d_read = 1'b0;
    i_read = 1'b1;
    i_address = 32'h80;
    held = 0;
    for (int k = 0; k < TO; k++) begin
      smp();
      if (mem_read && !err_timeout && !d_resp && !i_resp) held++;
      tick();
    end
    smp();
    chk("timeout_hold_cycles", held, TO);
    chk("timeout_flag", err_timeout, 1);
    chk("timeout_strobes_drop", {mem_read, mem_write, d_resp, i_resp}, 0);
    tick();
    smp();
    chk("timeout_then_fetch", {mem_read, mem_address}, {1'b1, 32'h80});
    tick();
    m_resp = 1'b1;
    smp();
    chk("timeout_fetch_resp", {i_resp, d_resp}, 2'b10);
    tick();
    m_resp = 1'b0;
    i_read = 1'b0;

    // Reset during a write.
    tick();
    d_write = 1'b1;
    d_address = 32'h1020;
    d_wdata = 32'h1234_5678;
    d_byte_enable = 4'hF;
    tick();
    d_write = 1'b0;
    smp();
    chk("pre_reset_write", mem_write, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_strobe", {mem_write, mem_read}, 0);
    chk("async_reset_err", {err_timeout, err_proto}, 0);
    chk("async_reset_addr", mem_address, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    m_resp = 1'b1;
    smp();
    chk("post_reset_resp_ignored", {d_resp, i_resp, mem_write}, 0);
    tick();
    m_resp = 1'b0;

    // Randomized contention from a fresh reset state (last grant = data).
    lg = 1;
    p_low = 1'b1;
    p_ireq = 1'b0;
    p_dreq = 1'b0;
    mon_en = 1'b1;
    auto_en = 1'b1;
    tick();
    fork
      run_i(40);
      run_d(40);
    join
    repeat (3) tick();
    smp();
    mon_en = 1'b0;
    auto_en = 1'b0;
    if (grant_log.size() < 2) fail("grant_log", "fewer than two grants recorded");
    else begin
      chk("contend_first_i", grant_log[0], 0);
      chk("contend_second_d", grant_log[1], 1);
    end
    chk("grant_count", grant_log.size(), 80);
    chk("i_queue_drained", i_exp_q.size(), 0);
    chk("d_queue_drained", d_exp_q.size(), 0);
    chk("random_no_errors", {err_timeout, err_proto}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
